// File: rtl/serial_cmp_pkg.sv
// Shared types and helpers for the MSB-first serial compare datapath.
package serial_cmp_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Bit-index register width; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_pair_serializer_msb_first.sv
// Serializes parallel operand pairs MSB first, one bit-pair per cycle,
// with a one-entry pending buffer so consecutive words stream without a gap.
module serial_pair_serializer_msb_first
  import serial_cmp_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  output logic             out_a,
  output logic             out_b,
  output logic             out_first,
  output logic             out_last
);

  localparam int unsigned   IW      = idx_width(WIDTH);
  localparam logic [IW-1:0] IDX_MSB = IW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] pa_q, pa_d;
  logic [WIDTH-1:0] pb_q, pb_d;
  logic             pend_q, pend_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             xfer;

  // Handshake: a pair transfers on any clk edge where in_valid && in_ready;
  // in_ready only depends on reset and pending occupancy, never on in_valid.
  assign in_ready = !rst && !pend_q;
  assign xfer     = in_valid && in_ready;

  assign out_valid = (state_q == ST_SHIFT);
  assign out_a     = out_valid && sa_q[WIDTH-1];
  assign out_b     = out_valid && sb_q[WIDTH-1];
  assign out_first = out_valid && (idx_q == IDX_MSB);
  assign out_last  = out_valid && (idx_q == '0);

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    pa_d    = pa_q;
    pb_d    = pb_q;
    pend_d  = pend_q;
    idx_d   = idx_q;
    unique case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          sa_d    = in_a;
          sb_d    = in_b;
          idx_d   = IDX_MSB;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (idx_q != '0) begin
          sa_d  = {sa_q[WIDTH-2:0], 1'b0};
          sb_d  = {sb_q[WIDTH-2:0], 1'b0};
          idx_d = idx_q - IW'(1);
          if (xfer) begin
            pa_d   = in_a;
            pb_d   = in_b;
            pend_d = 1'b1;
          end
        end else if (pend_q) begin
          // xfer cannot fire here: in_ready is low while pending is full.
          sa_d   = pa_q;
          sb_d   = pb_q;
          pend_d = 1'b0;
          idx_d  = IDX_MSB;
        end else if (xfer) begin
          sa_d  = in_a;
          sb_d  = in_b;
          idx_d = IDX_MSB;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      pa_q    <= '0;
      pb_q    <= '0;
      pend_q  <= 1'b0;
      idx_q   <= IDX_MSB;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      pa_q    <= pa_d;
      pb_q    <= pb_d;
      pend_q  <= pend_d;
      idx_q   <= idx_d;
    end
  end

endmodule
